gpr_wb_unit: RTL and testbench

Write-back sequencer that drives the register file write port (RegWr, waddr, busW, OV) in the multi-cycle MIPS.
- Accepts one write-back request per handshake from the main control FSM.
- Selects destination register and source value, and performs load-data lane extraction and extension.
- Computes signed add/sub overflow and presents a single-cycle write strobe to the GPR.
- Counts overflow events and flags misaligned loads.

---
 rtl/gpr_wb_unit_if.sv | 37 +++
 rtl/gpr_wb_unit.sv | 143 ++++++++++++++
 tb/tb_gpr_wb_unit.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_unit_if.sv
// Write-back request channel between the main control FSM and gpr_wb_unit.
// Carries valid/ready/done/err handshake plus all request operand fields.
interface gpr_wb_unit_if;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_done;
    logic        wb_err;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_src;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [1:0]  addr_lo;
    logic [31:0] alu_res;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        ov_chk;
    logic        ov_sub;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;

    modport master (
        output wb_valid, rt, rd, reg_dst, wb_src, ld_size, ld_unsigned,
        output addr_lo, alu_res, alu_a, alu_b, ov_chk, ov_sub,
        output mem_rdata, pc_plus4, imm16,
        input  wb_ready, wb_done, wb_err
    );

    modport slave (
        input  wb_valid, rt, rd, reg_dst, wb_src, ld_size, ld_unsigned,
        input  addr_lo, alu_res, alu_a, alu_b, ov_chk, ov_sub,
        input  mem_rdata, pc_plus4, imm16,
        output wb_ready, wb_done, wb_err
    );
endinterface

// File: rtl/gpr_wb_unit.sv
// GPR write-back sequencer: IDLE -> WRITE -> DONE, one GPR write per accept.
// Ports: clk, reset, wb (request slave), RegWr/waddr/busW/OV to GPR, ov_cnt.
module gpr_wb_unit #(
    parameter int RA_REG   = 31,
    parameter int OV_CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    gpr_wb_unit_if.slave        wb,
    output logic                RegWr,
    output logic [4:0]          waddr,
    output logic [31:0]         busW,
    output logic                OV,
    output logic [OV_CNT_W-1:0] ov_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] RA = 5'(RA_REG);
    localparam logic [OV_CNT_W-1:0] CNT_ONE = {{(OV_CNT_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic        wen_q, ov_q, err_q;
    logic        accept;
    logic [4:0]  dst;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_val;
    logic [31:0] src_val;
    logic [31:0] arith;
    logic        a_s, b_s, r_s;
    logic        ovf, ov_d, mis, wen_d;

    assign accept = (state_q == IDLE) && wb.wb_valid;

    always_comb begin
        unique case (wb.reg_dst)
            2'b01:   dst = wb.rd;
            2'b10:   dst = RA;
            default: dst = wb.rt;
        endcase
    end

    // Lane pick: byte lane n starts at bit 8n; halves split on addr_lo[1].
    assign lane_b = wb.mem_rdata[{wb.addr_lo, 3'b000} +: 8];
    assign lane_h = wb.addr_lo[1] ? wb.mem_rdata[31:16]
                                  : wb.mem_rdata[15:0];

    always_comb begin
        unique case (wb.ld_size)
            2'b01:   ld_val = {{16{~wb.ld_unsigned & lane_h[15]}}, lane_h};
            2'b10:   ld_val = {{24{~wb.ld_unsigned & lane_b[7]}}, lane_b};
            default: ld_val = wb.mem_rdata;
        endcase
    end

    always_comb begin
        mis = 1'b0;
        if (wb.wb_src == 2'b01) begin
            unique case (wb.ld_size)
                2'b01:   mis = wb.addr_lo[0];
                2'b10:   mis = 1'b0;
                default: mis = (wb.addr_lo != 2'b00);
            endcase
        end
    end

    always_comb begin
        unique case (wb.wb_src)
            2'b00:   src_val = wb.alu_res;
            2'b01:   src_val = ld_val;
            2'b10:   src_val = wb.pc_plus4;
            default: src_val = {wb.imm16, 16'h0000};
        endcase
    end

    // Overflow only possible when signs agree (add) or differ (sub).
    assign arith = wb.ov_sub ? (wb.alu_a - wb.alu_b) : (wb.alu_a + wb.alu_b);
    assign a_s   = wb.alu_a[31];
    assign b_s   = wb.alu_b[31];
    assign r_s   = arith[31];
    assign ovf   = wb.ov_sub ? ((a_s != b_s) && (r_s != a_s))
                             : ((a_s == b_s) && (r_s != a_s));
    assign ov_d  = wb.ov_chk && (wb.wb_src == 2'b00) && ovf;
    assign wen_d = !mis && (dst != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        RegWr       = 1'b0;
        OV          = 1'b0;
        wb.wb_ready = 1'b0;
        wb.wb_done  = 1'b0;
        wb.wb_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wb.wb_ready = 1'b1;
                if (wb.wb_valid) state_d = WRITE;
            end
            WRITE: begin
                RegWr   = wen_q;
                OV      = ov_q;
                state_d = DONE;
            end
            DONE: begin
                wb.wb_done = 1'b1;
                wb.wb_err  = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Results are computed at accept so ov_cnt already counts during WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr  <= '0;
            busW   <= '0;
            wen_q  <= 1'b0;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
            ov_cnt <= '0;
        end else if (accept) begin
            waddr <= dst;
            busW  <= src_val;
            wen_q <= wen_d;
            ov_q  <= ov_d;
            err_q <= mis;
            if (ov_d && (ov_cnt != '1)) ov_cnt <= ov_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_gpr_wb_unit.sv
// Testbench for gpr_wb_unit: directed scenarios plus randomized requests
// checked against an arithmetic reference model of the write-back rules.
module tb_gpr_wb_unit;
    logic        clk;
    logic        reset;
    logic        RegWr;
    logic [4:0]  waddr;
    logic [31:0] busW;
    logic        OV;
    logic [15:0] ov_cnt;

    int errors = 0;
    int checks = 0;

    gpr_wb_unit_if intf ();

    gpr_wb_unit #(.RA_REG(31), .OV_CNT_W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .wb     (intf.slave),
        .RegWr  (RegWr),
        .waddr  (waddr),
        .busW   (busW),
        .OV     (OV),
        .ov_cnt (ov_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observations
    logic        o_rdy_i, o_rdy_w;
    logic        o_w_we, o_w_ov, o_w_done;
    logic [4:0]  o_w_wa;
    logic [31:0] o_w_bw;
    logic [15:0] o_w_cnt;
    logic        o_d_done, o_d_err, o_d_we, o_d_ov;

    // model expectations
    logic [4:0]  e_wa;
    logic [31:0] e_bw;
    logic        e_we, e_ov, e_err;
    int unsigned e_cnt = 0;

    task automatic clear_req();
        intf.wb_valid    = 1'b0;
        intf.rt          = '0;
        intf.rd          = '0;
        intf.reg_dst     = '0;
        intf.wb_src      = '0;
        intf.ld_size     = '0;
        intf.ld_unsigned = 1'b0;
        intf.addr_lo     = '0;
        intf.alu_res     = '0;
        intf.alu_a       = '0;
        intf.alu_b       = '0;
        intf.ov_chk      = 1'b0;
        intf.ov_sub      = 1'b0;
        intf.mem_rdata   = '0;
        intf.pc_plus4    = '0;
        intf.imm16       = '0;
    endtask

    // Drive one accepted request and record WRITE / DONE cycle outputs.
    task automatic run_req();
        @(negedge clk);
        o_rdy_i = intf.wb_ready;
        intf.wb_valid = 1'b1;
        @(posedge clk);
        #1 intf.wb_valid = 1'b0;
        @(negedge clk);
        o_w_we   = RegWr;
        o_w_wa   = waddr;
        o_w_bw   = busW;
        o_w_ov   = OV;
        o_w_cnt  = ov_cnt;
        o_rdy_w  = intf.wb_ready;
        o_w_done = intf.wb_done;
        @(negedge clk);
        o_d_done = intf.wb_done;
        o_d_err  = intf.wb_err;
        o_d_we   = RegWr;
        o_d_ov   = OV;
    endtask

    // Reference: register-file write semantics from plain arithmetic.
    function automatic void model();
        longint sa, sb, r;
        int unsigned nbytes;
        logic [31:0] v;
        logic [31:0] m;
        m = intf.mem_rdata;
        unique case (intf.reg_dst)
            2'b01:   e_wa = intf.rd;
            2'b10:   e_wa = 5'd31;
            default: e_wa = intf.rt;
        endcase
        if (intf.ld_size == 2'b10) begin
            nbytes = 1;
            v = (m >> (8 * intf.addr_lo)) & 32'hFF;
            if (!intf.ld_unsigned) v = (v ^ 32'h80) - 32'h80;
        end else if (intf.ld_size == 2'b01) begin
            nbytes = 2;
            v = (m >> (intf.addr_lo[1] ? 16 : 0)) & 32'hFFFF;
            if (!intf.ld_unsigned) v = (v ^ 32'h8000) - 32'h8000;
        end else begin
            nbytes = 4;
            v = m;
        end
        e_err = (intf.wb_src == 2'b01) && ((intf.addr_lo % nbytes) != 0);
        unique case (intf.wb_src)
            2'b00:   e_bw = intf.alu_res;
            2'b01:   e_bw = v;
            2'b10:   e_bw = intf.pc_plus4;
            default: e_bw = intf.imm16 * 32'h10000;
        endcase
        sa = longint'($signed(intf.alu_a));
        sb = longint'($signed(intf.alu_b));
        r  = intf.ov_sub ? sa - sb : sa + sb;
        e_ov = intf.ov_chk && (intf.wb_src == 2'b00)
               && (r > 64'sd2147483647 || r < -64'sd2147483648);
        e_we = !e_err && (e_wa != 0);
        if (e_ov && e_cnt < 65535) e_cnt++;
    endfunction

    task automatic test_reset();
        clear_req();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({RegWr, OV, intf.wb_done, intf.wb_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {RegWr, OV, intf.wb_done, intf.wb_err});
        end
        checks++;
        if ({waddr, busW, ov_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_regs waddr=%h busW=%h cnt=%h exp=0",
                     waddr, busW, ov_cnt);
        end
        checks++;
        if (intf.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", intf.wb_ready);
        end
        reset = 1'b0;
        e_cnt = 0;
    endtask

    task automatic test_basic();
        clear_req();
        intf.reg_dst = 2'b01;
        intf.rd      = 5'd5;
        intf.alu_res = 32'h1234;
        model();
        run_req();
        checks++;
        if ({o_rdy_i, o_rdy_w} !== 2'b10) begin
            errors++;
            $display("FAIL basic_ready got=%b exp=10", {o_rdy_i, o_rdy_w});
        end
        checks++;
        if ({o_w_we, o_w_wa, o_w_bw, o_w_ov, o_w_done} !==
            {1'b1, 5'd5, 32'h1234, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_write we=%b wa=%0d bw=%h ov=%b done=%b exp 1/5/1234/0/0",
                     o_w_we, o_w_wa, o_w_bw, o_w_ov, o_w_done);
        end
        checks++;
        if ({o_d_done, o_d_err, o_d_we, o_d_ov} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_done got=%b exp=1000",
                     {o_d_done, o_d_err, o_d_we, o_d_ov});
        end
    endtask

    task automatic test_overflow();
        logic [31:0] aa [3] = '{32'h7FFFFFFF, 32'h80000000, 32'd5};
        logic [31:0] bb [3] = '{32'd1, 32'd1, 32'd3};
        logic        ss [3] = '{1'b0, 1'b1, 1'b0};
        logic        eo [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] ec [3] = '{16'd1, 16'd2, 16'd2};
        for (int i = 0; i < 3; i++) begin
            clear_req();
            intf.reg_dst = 2'b01;
            intf.rd      = 5'd9;
            intf.ov_chk  = 1'b1;
            intf.ov_sub  = ss[i];
            intf.alu_a   = aa[i];
            intf.alu_b   = bb[i];
            intf.alu_res = 32'hDEAD0000 + i;
            model();
            run_req();
            checks++;
            if ({o_w_ov, o_w_we, o_w_cnt} !== {eo[i], 1'b1, ec[i]}) begin
                errors++;
                $display("FAIL ovf_%0d ov=%b we=%b cnt=%0d exp ov=%b we=1 cnt=%0d",
                         i, o_w_ov, o_w_we, o_w_cnt, eo[i], ec[i]);
            end
            checks++;
            if (o_d_ov !== 1'b0) begin
                errors++;
                $display("FAIL ovf_done_%0d ov=%b exp=0", i, o_d_ov);
            end
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz [4] = '{2'b10, 2'b10, 2'b01, 2'b10};
        logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  al [4] = '{2'd3, 2'd3, 2'd2, 2'd1};
        logic [31:0] ev [4] = '{32'hFFFFFF80, 32'h00000080,
                                32'hFFFF80FF, 32'h0000007F};
        for (int i = 0; i < 4; i++) begin
            clear_req();
            intf.wb_src      = 2'b01;
            intf.rt          = 5'd7;
            intf.mem_rdata   = 32'h80FF7F01;
            intf.ld_size     = sz[i];
            intf.ld_unsigned = un[i];
            intf.addr_lo     = al[i];
            model();
            run_req();
            checks++;
            if ({o_w_we, o_w_wa, o_w_bw} !== {1'b1, 5'd7, ev[i]}) begin
                errors++;
                $display("FAIL load_%0d we=%b wa=%0d bw=%h exp we=1 wa=7 bw=%h",
                         i, o_w_we, o_w_wa, o_w_bw, ev[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0] sz [2] = '{2'b01, 2'b00};
        logic [1:0] al [2] = '{2'd1, 2'd2};
        for (int i = 0; i < 2; i++) begin
            clear_req();
            intf.wb_src    = 2'b01;
            intf.rt        = 5'd3;
            intf.mem_rdata = 32'h12345678;
            intf.ld_size   = sz[i];
            intf.addr_lo   = al[i];
            model();
            run_req();
            checks++;
            if ({o_w_we, o_w_ov, o_d_we, o_d_done, o_d_err} !== 5'b00011) begin
                errors++;
                $display("FAIL misalign_%0d we/ov/dwe/done/err=%b exp=00011",
                         i, {o_w_we, o_w_ov, o_d_we, o_d_done, o_d_err});
            end
        end
    endtask

    task automatic test_link_zero();
        clear_req();
        intf.reg_dst  = 2'b10;
        intf.wb_src   = 2'b10;
        intf.pc_plus4 = 32'h00003004;
        model();
        run_req();
        checks++;
        if ({o_w_we, o_w_wa, o_w_bw} !== {1'b1, 5'd31, 32'h00003004}) begin
            errors++;
            $display("FAIL link we=%b wa=%0d bw=%h exp 1/31/00003004",
                     o_w_we, o_w_wa, o_w_bw);
        end
        clear_req();
        intf.reg_dst = 2'b00;
        intf.rt      = 5'd0;
        intf.wb_src  = 2'b11;
        intf.imm16   = 16'hBEEF;
        model();
        run_req();
        checks++;
        if ({o_w_we, o_w_bw, o_d_done, o_d_err} !== {1'b0, 32'hBEEF0000, 2'b10}) begin
            errors++;
            $display("FAIL r0_lui we=%b bw=%h done=%b err=%b exp 0/beef0000/1/0",
                     o_w_we, o_w_bw, o_d_done, o_d_err);
        end
    endtask

    task automatic test_back_to_back();
        int nwr;
        clear_req();
        intf.reg_dst = 2'b01;
        intf.rd      = 5'd12;
        intf.alu_res = 32'hCAFE;
        model();
        @(negedge clk);
        intf.wb_valid = 1'b1;
        @(posedge clk);
        nwr = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (RegWr === 1'b1) nwr++;
        end
        checks++;
        if (intf.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready got=%b exp=1", intf.wb_ready);
        end
        intf.wb_valid = 1'b0;
        checks++;
        if (nwr !== 1) begin
            errors++;
            $display("FAIL hold_single_write writes=%0d exp=1", nwr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            clear_req();
            intf.rt          = 5'($urandom);
            intf.rd          = 5'($urandom);
            intf.reg_dst     = 2'($urandom);
            intf.wb_src      = 2'($urandom);
            intf.ld_size     = 2'($urandom);
            intf.ld_unsigned = 1'($urandom);
            intf.addr_lo     = 2'($urandom);
            intf.alu_res     = $urandom;
            intf.alu_a       = $urandom_range(1) ? $urandom : 32'h7FFFFFF0 + $urandom_range(31);
            intf.alu_b       = $urandom_range(1) ? $urandom : 32'($urandom_range(31)) - 32'd16;
            intf.ov_chk      = 1'($urandom);
            intf.ov_sub      = 1'($urandom);
            intf.mem_rdata   = $urandom;
            intf.pc_plus4    = $urandom;
            intf.imm16       = 16'($urandom);
            model();
            run_req();
            checks++;
            if ({o_w_we, o_w_ov, o_w_wa} !== {e_we, e_ov, e_wa}) begin
                errors++;
                $display("FAIL rnd_%0d_ctl we=%b ov=%b wa=%0d exp we=%b ov=%b wa=%0d",
                         i, o_w_we, o_w_ov, o_w_wa, e_we, e_ov, e_wa);
            end
            checks++;
            if (!e_err && o_w_bw !== e_bw) begin
                errors++;
                $display("FAIL rnd_%0d_busW got=%h exp=%h", i, o_w_bw, e_bw);
            end
            checks++;
            if ({o_d_done, o_d_err, o_w_cnt} !== {1'b1, e_err, 16'(e_cnt)}) begin
                errors++;
                $display("FAIL rnd_%0d_done done=%b err=%b cnt=%0d exp 1/%b/%0d",
                         i, o_d_done, o_d_err, o_w_cnt, e_err, e_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        clear_req();
        intf.reg_dst = 2'b01;
        intf.rd      = 5'd4;
        intf.ov_chk  = 1'b1;
        intf.alu_a   = 32'h7FFFFFFF;
        intf.alu_b   = 32'd1;
        @(negedge clk);
        intf.wb_valid = 1'b1;
        @(posedge clk);
        #1 intf.wb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (RegWr !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre RegWr=%b exp=1", RegWr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({RegWr, OV, intf.wb_ready, ov_cnt} !== {3'b001, 16'd0}) begin
            errors++;
            $display("FAIL rmid_now we=%b ov=%b rdy=%b cnt=%0d exp 0/0/1/0",
                     RegWr, OV, intf.wb_ready, ov_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        e_cnt = 0;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (intf.wb_done === 1'b1 || RegWr === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL rmid_after strobes=%0d exp=0", ndone);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clear_req();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_loads();
        test_misaligned();
        test_link_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
